// File: rtl/irq_controller_if.sv
// CPU-side signal bundle for irq_controller: data-bus responder and IRQ/IRQn/IRQAck handshake.
interface irq_controller_if;
  logic [13:0] dataAddress;
  logic [31:0] dataWrData;
  logic        dataWrEn;
  logic [31:0] rdData;
  logic        rdHit;
  logic        IRQ;
  logic [11:0] IRQn;
  logic        IRQAck;

  modport master (
    output dataAddress, dataWrData, dataWrEn, IRQAck,
    input  rdData, rdHit, IRQ, IRQn
  );

  modport slave (
    input  dataAddress, dataWrData, dataWrEn, IRQAck,
    output rdData, rdHit, IRQ, IRQn
  );
endinterface

// File: rtl/irq_controller.sv
// Vectored interrupt controller: edge-latched pending, enable mask, fixed priority, CPU handshake.
// Define IRQ_SYNC_EN to put a 2-flop synchronizer on each irqIn line ahead of edge detection.
module irq_controller #(
  parameter int unsigned NUM_IRQ   = 8,
  parameter logic [13:0] BASE_ADDR = 14'h3F00
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic [NUM_IRQ-1:0] irqIn,
  irq_controller_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StReq, StAckWait, StInSvc} state_e;

  state_e              state_q, state_d;
  logic [NUM_IRQ-1:0]  en_q, en_d;
  logic [NUM_IRQ-1:0]  pend_q, pend_d;
  logic [NUM_IRQ-1:0]  prev_q;
  logic [11:0]         vec_q [NUM_IRQ];
  logic [11:0]         vec_d [NUM_IRQ];
  logic [3:0]          id_q, id_d;
  logic                irq_q, irq_d;
  logic [11:0]         irqn_q, irqn_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic                rd_hit_q, rd_hit_d;

  logic [NUM_IRQ-1:0]  sample;
  logic [NUM_IRQ-1:0]  rising;
  logic [NUM_IRQ-1:0]  req;
  logic [NUM_IRQ-1:0]  w1c;
  logic [NUM_IRQ-1:0]  svc_clr;
  logic [3:0]          sel;
  logic                any_req;
  logic                eoi;
  logic [13:0]         off;
  logic                in_range;
  logic                wr;
  logic                unused_wr_data;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irqIn;
      sync2_q <= sync1_q;
    end
  end

  assign sample = sync2_q;
`else
  assign sample = irqIn;
`endif

  assign off      = bus.dataAddress - BASE_ADDR;
  assign in_range = (bus.dataAddress >= BASE_ADDR) && (off < 14'(4 + NUM_IRQ));
  assign wr       = bus.dataWrEn && in_range;
  assign rising   = sample & ~prev_q;
  assign req      = pend_q & en_q;
  assign any_req  = |req;
  assign unused_wr_data = ^bus.dataWrData;

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) sel = 4'(i);
    end
  end

  // Register writes
  always_comb begin
    en_d  = en_q;
    vec_d = vec_q;
    w1c   = '0;
    eoi   = 1'b0;
    if (wr) begin
      case (off)
        14'd0:   en_d = bus.dataWrData[NUM_IRQ-1:0];
        14'd1:   w1c  = bus.dataWrData[NUM_IRQ-1:0];
        14'd2:   eoi  = 1'b1;
        14'd3:   ;
        default: begin
          for (int i = 0; i < NUM_IRQ; i++) begin
            if (off == 14'(4 + i)) vec_d[i] = bus.dataWrData[11:0];
          end
        end
      endcase
    end
  end

  // Request state machine
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    irq_d   = irq_q;
    irqn_d  = irqn_q;
    svc_clr = '0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          id_d         = sel;
          irq_d        = 1'b1;
          irqn_d       = vec_q[sel];
          svc_clr[sel] = 1'b1;
          state_d      = StReq;
        end
      end
      StReq: begin
        if (bus.IRQAck) begin
          irq_d   = 1'b0;
          state_d = StAckWait;
        end
      end
      StAckWait: begin
        if (!bus.IRQAck) state_d = StInSvc;
      end
      StInSvc: begin
        if (eoi) begin
          id_d    = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A fresh edge wins over a same-edge clear.
  assign pend_d = (pend_q & ~w1c & ~svc_clr) | rising;

  // Read mux, registered for one-cycle latency
  always_comb begin
    rd_hit_d  = in_range;
    rd_data_d = '0;
    if (in_range) begin
      case (off)
        14'd0:   rd_data_d = 32'(en_q);
        14'd1:   rd_data_d = 32'(pend_q);
        14'd2:   rd_data_d = '0;
        14'd3:   rd_data_d = {22'd0, state_q == StInSvc,
                              (state_q == StReq) || (state_q == StAckWait), 4'd0, id_q};
        default: begin
          for (int i = 0; i < NUM_IRQ; i++) begin
            if (off == 14'(4 + i)) rd_data_d = {20'd0, vec_q[i]};
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= StIdle;
      en_q      <= '0;
      pend_q    <= '0;
      prev_q    <= '0;
      id_q      <= '0;
      irq_q     <= 1'b0;
      irqn_q    <= '0;
      rd_data_q <= '0;
      rd_hit_q  <= 1'b0;
      for (int i = 0; i < NUM_IRQ; i++) vec_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      pend_q    <= pend_d;
      prev_q    <= sample;
      id_q      <= id_d;
      irq_q     <= irq_d;
      irqn_q    <= irqn_d;
      rd_data_q <= rd_data_d;
      rd_hit_q  <= rd_hit_d;
      for (int i = 0; i < NUM_IRQ; i++) vec_q[i] <= vec_d[i];
    end
  end

  assign bus.IRQ    = irq_q;
  assign bus.IRQn   = irqn_q;
  assign bus.rdData = rd_data_q;
  assign bus.rdHit  = rd_hit_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with a per-cycle reference model and literal spot checks.
module tb_irq_controller;
  localparam int N = 8;
  localparam logic [13:0] BASE = 14'h3F00;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int PH_IDLE = 0, PH_REQ = 1, PH_ACKW = 2, PH_SVC = 3;

  logic         clk;
  logic         nRst;
  logic [N-1:0] irqIn;
  irq_controller_if bus ();

  irq_controller #(.NUM_IRQ(N), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .nRst  (nRst),
    .irqIn (irqIn),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [N-1:0] m_en, m_pend, m_prev, m_s1, m_s2;
  logic [11:0]  m_vec [N];
  int           m_phase, m_id;
  logic         m_irq, m_hit;
  logic [11:0]  m_irqn;
  logic [31:0]  m_rd;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = '0; m_pend = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
    for (int i = 0; i < N; i++) m_vec[i] = '0;
    m_phase = PH_IDLE; m_id = 0; m_irq = 0; m_irqn = '0; m_hit = 0; m_rd = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] s, rise, np, nen;
    int off, win, vidx;
    logic hit, eoi;
    logic [31:0] nrd;
`ifdef IRQ_SYNC_EN
    s = m_s2; m_s2 = m_s1; m_s1 = irqIn;
`else
    s = irqIn;
`endif
    rise = s & ~m_prev;
    m_prev = s;
    off = int'(bus.dataAddress) - int'(BASE);
    hit = (off >= 0) && (off < 4 + N);
    nrd = '0;
    if (hit) begin
      if (off == 0) nrd = 32'(m_en);
      else if (off == 1) nrd = 32'(m_pend);
      else if (off == 3) nrd = ((m_phase == PH_SVC) ? 32'h200 : 32'h0)
                             + ((m_phase == PH_REQ || m_phase == PH_ACKW) ? 32'h100 : 32'h0)
                             + 32'(m_id);
      else if (off >= 4) nrd = 32'(m_vec[off-4]);
    end
    win = -1;
    for (int i = 0; i < N; i++) if (win < 0 && m_pend[i] && m_en[i]) win = i;
    np = m_pend; nen = m_en; eoi = 0; vidx = -1;
    if (bus.dataWrEn && hit) begin
      if (off == 0) nen = bus.dataWrData[N-1:0];
      else if (off == 1) np = np & ~bus.dataWrData[N-1:0];
      else if (off == 2) eoi = 1;
      else if (off >= 4) vidx = off - 4;
    end
    case (m_phase)
      PH_IDLE: if (win >= 0) begin
        m_irq = 1; m_irqn = m_vec[win]; m_id = win; np[win] = 1'b0; m_phase = PH_REQ;
      end
      PH_REQ:  if (bus.IRQAck) begin m_irq = 0; m_phase = PH_ACKW; end
      PH_ACKW: if (!bus.IRQAck) m_phase = PH_SVC;
      default: if (eoi) begin m_phase = PH_IDLE; m_id = 0; end
    endcase
    if (vidx >= 0) m_vec[vidx] = bus.dataWrData[11:0];
    m_pend = np | rise;
    m_en = nen;
    m_rd = nrd;
    m_hit = hit;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge nRst);
      if (!nRst) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (nRst === 1'b1) begin
      chk("model IRQ", 32'(bus.IRQ), 32'(m_irq));
      chk("model IRQn", 32'(bus.IRQn), 32'(m_irqn));
      chk("model rdHit", 32'(bus.rdHit), 32'(m_hit));
      chk("model rdData", bus.rdData, m_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    bus.dataAddress = BASE + 14'(off);
    bus.dataWrData  = d;
    bus.dataWrEn    = 1'b1;
    tick();
    bus.dataWrEn    = 1'b0;
    bus.dataAddress = '0;
  endtask

  task automatic rd(input int off, input string nm, input logic [31:0] exp);
    bus.dataAddress = BASE + 14'(off);
    tick();
    chk({nm, " hit"}, 32'(bus.rdHit), 32'd1);
    chk(nm, bus.rdData, exp);
    bus.dataAddress = '0;
  endtask

  task automatic ack_cycle();
    bus.IRQAck = 1'b1;
    tick();
    bus.IRQAck = 1'b0;
    tick();
  endtask

  initial begin
    nRst = 1'b0; irqIn = '0;
    bus.dataAddress = '0; bus.dataWrData = '0; bus.dataWrEn = 1'b0; bus.IRQAck = 1'b0;
    repeat (2) tick();
    nRst = 1'b1;
    tick();

    // Reset values
    chk("reset IRQ", 32'(bus.IRQ), 32'd0);
    rd(0, "reset ENABLE", 32'd0);
    rd(1, "reset PENDING", 32'd0);
    rd(3, "reset STATUS", 32'd0);
    bus.dataAddress = BASE - 14'd1;
    tick();
    chk("below base rdHit", 32'(bus.rdHit), 32'd0);
    bus.dataAddress = '0;

    // Single request and full handshake
    wr(6, 32'h040);
    wr(0, 32'h04);
    irqIn = 8'h04;
    tick();
    irqIn = '0;
    repeat (LAT) tick();
    chk("irq2 not yet", 32'(bus.IRQ), 32'd0);
    tick();
    chk("irq2 IRQ", 32'(bus.IRQ), 32'd1);
    chk("irq2 IRQn", 32'(bus.IRQn), 32'h040);
    rd(3, "irq2 STATUS req", 32'h102);
    bus.IRQAck = 1'b1;
    tick();
    chk("irq2 acked", 32'(bus.IRQ), 32'd0);
    bus.IRQAck = 1'b0;
    tick();
    rd(3, "irq2 STATUS insvc", 32'h202);
    wr(2, 32'h0);
    rd(3, "irq2 STATUS idle", 32'h0);

    // Priority between simultaneous lines
    wr(0, 32'hFF);
    wr(5, 32'h100);
    wr(9, 32'h500);
    irqIn = 8'h22;
    tick();
    irqIn = '0;
    repeat (LAT) tick();
    tick();
    chk("prio first IRQn", 32'(bus.IRQn), 32'h100);
    ack_cycle();
    wr(2, 32'h0);
    chk("prio gap IRQ", 32'(bus.IRQ), 32'd0);
    tick();
    chk("prio second IRQ", 32'(bus.IRQ), 32'd1);
    chk("prio second IRQn", 32'(bus.IRQn), 32'h500);
    ack_cycle();
    wr(2, 32'h0);

    // Masked pending, W1C collision, then enable
    wr(0, 32'h00);
    irqIn = 8'h08;
    tick();
    irqIn = '0;
    repeat (LAT + 2) tick();
    chk("masked IRQ", 32'(bus.IRQ), 32'd0);
    rd(1, "masked PENDING", 32'h08);
    tick();
    irqIn = 8'h08;
    repeat (LAT) tick();
    wr(1, 32'h08);
    irqIn = '0;
    rd(1, "w1c vs edge PENDING", 32'h08);
    wr(0, 32'h08);
    tick();
    chk("enable IRQ", 32'(bus.IRQ), 32'd1);
    chk("enable IRQn", 32'(bus.IRQn), 32'h000);
    ack_cycle();

    // New edge while in service is held until EOI
    wr(0, 32'h01);
    irqIn = 8'h01;
    tick();
    irqIn = '0;
    repeat (LAT + 3) tick();
    chk("insvc hold IRQ", 32'(bus.IRQ), 32'd0);
    wr(4, 32'h321);
    wr(2, 32'h0);
    chk("eoi edge IRQ", 32'(bus.IRQ), 32'd0);
    tick();
    chk("post eoi IRQ", 32'(bus.IRQ), 32'd1);
    chk("post eoi IRQn", 32'(bus.IRQn), 32'h321);

    // Asynchronous reset mid-request
    #2 nRst = 1'b0;
    #1 chk("async reset IRQ", 32'(bus.IRQ), 32'd0);
    tick();
    nRst = 1'b1;
    tick();
    rd(0, "post reset ENABLE", 32'd0);
    rd(1, "post reset PENDING", 32'd0);
    rd(3, "post reset STATUS", 32'd0);
    rd(4, "post reset VECTOR0", 32'd0);
    rd(4 + N - 1, "post reset VECTOR7", 32'd0);
    bus.dataAddress = BASE + 14'(4 + N);
    tick();
    chk("above top rdHit", 32'(bus.rdHit), 32'd0);
    bus.dataAddress = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
